// File: rtl/input_event_encoder_pkg.sv
// Shared constants for the input event encoder: event-byte bit positions,
// compass button indices, FSM state encoding and a small bit-count helper.
package input_event_pkg;

  // Bit positions inside the event byte, MSB to LSB
  localparam int EV_CENTER    = 7;
  localparam int EV_NORTH     = 6;
  localparam int EV_EAST      = 5;
  localparam int EV_SOUTH     = 4;
  localparam int EV_WEST      = 3;
  localparam int EV_ROT_PUSH  = 2;
  localparam int EV_ROT_EVENT = 1;
  localparam int EV_ROT_LEFT  = 0;

  // Index of each compass button inside the compass_buttons bus
  localparam int BTN_C = 0;
  localparam int BTN_E = 1;
  localparam int BTN_N = 2;
  localparam int BTN_S = 3;
  localparam int BTN_W = 4;

  // Emitter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Number of set bits in a 6-bit vector (pending-event mask width)
  function automatic logic [2:0] count_ones6(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/input_event_encoder_if.sv
// Write-side connection to the CPU input-event FIFO: registered byte and
// strobe from the encoder, full flag back from the FIFO.
interface input_event_encoder_if;
  logic [7:0] fifo_din;
  logic       fifo_wr_en;
  logic       fifo_full;

  modport master (output fifo_din, output fifo_wr_en, input fifo_full);
  modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/input_event_encoder_rotary_step_accumulator.sv
// Saturating signed net-rotation counter. A detent step and a step toward
// zero (taken when a byte is emitted) may land on the same edge; both are
// summed in a wider signed value and then clamped to +/-(2^(W-1)-1).
module rotary_step_accumulator #(
  parameter int ROT_CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  input  logic step_left,
  input  logic step_zero,
  output logic nonzero,
  output logic negative,
  output logic sat_drop
);
  localparam int W = ROT_CNT_WIDTH;
  localparam logic signed [W+1:0] LIM_POS = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] LIM_NEG = -LIM_POS;
  localparam logic signed [W+1:0] ONE     = {{(W+1){1'b0}}, 1'b1};

  logic signed [W-1:0] cnt;
  logic signed [W+1:0] step_ext;
  logic signed [W+1:0] zero_ext;
  logic signed [W+1:0] sum_ext;

  // Clamp the widened sum back into the symmetric counter range
  function automatic logic signed [W-1:0] sat_cnt(input logic signed [W+1:0] v);
    if (v > LIM_POS)      return $signed(LIM_POS[W-1:0]);
    else if (v < LIM_NEG) return $signed(LIM_NEG[W-1:0]);
    else                  return $signed(v[W-1:0]);
  endfunction

  // Combine detent delta and decay-toward-zero delta in one signed sum
  always_comb begin
    step_ext = '0;
    if (step_in) step_ext = step_left ? '1 : ONE;
    zero_ext = '0;
    if (step_zero && (cnt != '0)) zero_ext = cnt[W-1] ? ONE : '1;
    sum_ext  = $signed({{2{cnt[W-1]}}, cnt}) + step_ext + zero_ext;
    sat_drop = (sum_ext > LIM_POS) || (sum_ext < LIM_NEG);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= sat_cnt(sum_ext);
  end

  assign nonzero  = (cnt != '0);
  assign negative = cnt[W-1];

endmodule

// File: rtl/input_event_encoder.sv
// Input event encoder: turns one-cycle button/rotary pulses into event bytes
// for the CPU input FIFO, accumulating them while the FIFO is full.
// Optional feature macro: DROP_COUNTER_EN enables the merged/lost event counter.
module input_event_encoder
  import input_event_pkg::*;
#(
  parameter int ROT_CNT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   compass_buttons,
  input  logic                         rotary_push,
  input  logic                         rotary_event,
  input  logic                         rotary_left,
  input_event_encoder_if.master        fifo,
  output logic [15:0]                  dropped_count
);
  // pend bits are kept in event-byte order (bit 5 = center ... bit 0 = push)
  logic [5:0] pend;
  logic [5:0] pend_set;
  logic [1:0] state;
  logic       emit;
  logic       rot_nonzero;
  logic       rot_negative;
  logic       sat_drop;

  assign pend_set = {compass_buttons[BTN_C], compass_buttons[BTN_N],
                     compass_buttons[BTN_E], compass_buttons[BTN_S],
                     compass_buttons[BTN_W], rotary_push};

  assign emit = (state == ST_IDLE) && ((|pend) || rot_nonzero) && !fifo.fifo_full;

  rotary_step_accumulator #(.ROT_CNT_WIDTH(ROT_CNT_WIDTH)) u_rot (
    .clk       (clk),
    .rst       (rst),
    .step_in   (rotary_event),
    .step_left (rotary_left),
    .step_zero (emit),
    .nonzero   (rot_nonzero),
    .negative  (rot_negative),
    .sat_drop  (sat_drop)
  );

  // Sticky pending bits; a pulse on the clearing edge survives into the next byte
  always_ff @(posedge clk) begin
    if (rst)       pend <= '0;
    else if (emit) pend <= pend_set;
    else           pend <= pend | pend_set;
  end

  // Emitter FSM: load byte, strobe one cycle, then one gap cycle for fifo_full to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      fifo.fifo_din   <= '0;
      fifo.fifo_wr_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (emit) begin
            state           <= ST_WRITE;
            fifo.fifo_din   <= {pend, rot_nonzero, rot_negative};
            fifo.fifo_wr_en <= 1'b1;
          end
        end
        ST_WRITE: begin
          state           <= ST_GAP;
          fifo.fifo_din   <= '0;
          fifo.fifo_wr_en <= 1'b0;
        end
        default: begin
          state           <= ST_IDLE;
          fifo.fifo_din   <= '0;
          fifo.fifo_wr_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef DROP_COUNTER_EN
  logic [2:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt;

  assign drop_inc = count_ones6(pend_set & pend & {6{~emit}}) + {2'b00, sat_drop};
  assign drop_sum = {1'b0, drop_cnt} + {14'b0, drop_inc};

  // Saturating count of merged button pulses and clipped rotary steps
  always_ff @(posedge clk) begin
    if (rst)              drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                  drop_cnt <= drop_sum[15:0];
  end

  assign dropped_count = drop_cnt;
`else
  logic unused_sat_drop;
  assign unused_sat_drop = sat_drop;
  assign dropped_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_input_event_encoder.sv
// Self-checking bench for input_event_encoder: a per-cycle vector table for
// the basic paths plus hand-written sequences for saturation, cancel and reset.
module tb_input_event_encoder;

`ifdef DROP_COUNTER_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  compass_buttons;
  logic        rotary_push;
  logic        rotary_event;
  logic        rotary_left;
  logic [15:0] dropped_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  input_event_encoder_if fifo_bus ();

  input_event_encoder #(.ROT_CNT_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .compass_buttons (compass_buttons),
    .rotary_push     (rotary_push),
    .rotary_event    (rotary_event),
    .rotary_left     (rotary_left),
    .fifo            (fifo_bus),
    .dropped_count   (dropped_count)
  );

  typedef struct {
    logic [4:0] btn;
    logic       push;
    logic       rot_ev;
    logic       rot_left;
    logic       full;
    logic       exp_wr;
    logic [7:0] exp_din;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    compass_buttons = '0;
    rotary_push     = 1'b0;
    rotary_event    = 1'b0;
    rotary_left     = 1'b0;
  endtask

  // Run n cycles, counting writes; each written byte must equal exp_byte,
  // writes must be 3 cycles apart and fifo_din must be 0 while wr_en is low.
  task automatic drain(input string name, input int n, input logic [7:0] exp_byte,
                       output int nwr);
    int last;
    int bad_byte;
    int bad_gap;
    int bad_idle;
    nwr = 0; last = -1; bad_byte = 0; bad_gap = 0; bad_idle = 0;
    for (int c = 0; c < n; c++) begin
      cycle();
      if (fifo_bus.fifo_wr_en) begin
        if (fifo_bus.fifo_din !== exp_byte) bad_byte++;
        if (last >= 0 && (c - last) != 3) bad_gap++;
        last = c;
        nwr++;
      end else if (fifo_bus.fifo_din !== 8'h00) begin
        bad_idle++;
      end
    end
    chk({name, "_bytes"}, 16'(bad_byte), 16'd0);
    chk({name, "_spacing"}, 16'(bad_gap), 16'd0);
    chk({name, "_idle_din"}, 16'(bad_idle), 16'd0);
  endtask

  initial begin
    int nwr;
    // btn bits: C=00001 E=00010 N=00100 S=01000 W=10000
    // North pulse -> one 0x40 write, then quiet
    vecs[0]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40};
    vecs[2]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    // Center pulse on the edge the North byte is loaded -> 0x40 then 0x80
    vecs[5]  = '{5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40};
    vecs[7]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
    vecs[10] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    // Right detent, then another on the emit edge -> two 0x02 bytes
    vecs[12] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02};
    vecs[14] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[15] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[16] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02};
    vecs[17] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[18] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    // FIFO full during E, W, push, push -> single merged 0x2C byte on release
    vecs[20] = '{5'b00010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[21] = '{5'b10000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[22] = '{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[23] = '{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[24] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[25] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2C};
    vecs[26] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[27] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[28] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state
    rst = 1'b1;
    clear_pulses();
    fifo_bus.fifo_full = 1'b0;
    repeat (3) cycle();
    chk("reset_wr_en", 16'(fifo_bus.fifo_wr_en), 16'd0);
    chk("reset_din", 16'(fifo_bus.fifo_din), 16'd0);
    chk("reset_dropped", dropped_count, 16'd0);
    rst = 1'b0;
    cycle();

    // Table-driven vectors
    for (int i = 0; i < 29; i++) begin
      compass_buttons    = vecs[i].btn;
      rotary_push        = vecs[i].push;
      rotary_event       = vecs[i].rot_ev;
      rotary_left        = vecs[i].rot_left;
      fifo_bus.fifo_full = vecs[i].full;
      cycle();
      chk($sformatf("vec%0d_wr_en", i), 16'(fifo_bus.fifo_wr_en), 16'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_din", i), 16'(fifo_bus.fifo_din), 16'(vecs[i].exp_din));
    end
    clear_pulses();
    chk("merge_dropped", dropped_count, DROP_EN ? 16'd1 : 16'd0);

    // Nine right detents while full: counter clips at +7, two steps dropped
    fifo_bus.fifo_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rotary_event = 1'b1;
      rotary_left  = 1'b0;
      cycle();
      chk($sformatf("sat_hold%0d_wr_en", i), 16'(fifo_bus.fifo_wr_en), 16'd0);
    end
    clear_pulses();
    cycle();
    chk("sat_dropped", dropped_count, DROP_EN ? 16'd3 : 16'd0);
    fifo_bus.fifo_full = 1'b0;
    drain("sat", 40, 8'h02, nwr);
    chk("sat_writes", 16'(nwr), 16'd7);

    // Three left then one right while full: net -2 -> two 0x03 bytes
    fifo_bus.fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rotary_event = 1'b1;
      rotary_left  = (i < 3);
      cycle();
    end
    clear_pulses();
    cycle();
    chk("cancel_hold_wr_en", 16'(fifo_bus.fifo_wr_en), 16'd0);
    fifo_bus.fifo_full = 1'b0;
    drain("cancel", 20, 8'h03, nwr);
    chk("cancel_writes", 16'(nwr), 16'd2);
    chk("cancel_dropped", dropped_count, DROP_EN ? 16'd3 : 16'd0);

    // Reset with pending South and rot_cnt = -2 discards everything
    fifo_bus.fifo_full = 1'b1;
    compass_buttons = 5'b01000;
    rotary_event = 1'b1;
    rotary_left  = 1'b1;
    cycle();
    compass_buttons = 5'b00000;
    cycle();
    clear_pulses();
    rst = 1'b1;
    cycle();
    chk("rst_pend_wr_en", 16'(fifo_bus.fifo_wr_en), 16'd0);
    chk("rst_pend_din", 16'(fifo_bus.fifo_din), 16'd0);
    chk("rst_pend_dropped", dropped_count, 16'd0);
    rst = 1'b0;
    fifo_bus.fifo_full = 1'b0;
    drain("rst_pend", 10, 8'h00, nwr);
    chk("rst_pend_writes", 16'(nwr), 16'd0);

    // Reset sampled during the write cycle forces wr_en low on the next cycle
    compass_buttons = 5'b00100;
    cycle();
    clear_pulses();
    cycle();
    chk("rst_mid_wr_en_before", 16'(fifo_bus.fifo_wr_en), 16'd1);
    chk("rst_mid_din_before", 16'(fifo_bus.fifo_din), 16'h40);
    rst = 1'b1;
    cycle();
    chk("rst_mid_wr_en", 16'(fifo_bus.fifo_wr_en), 16'd0);
    chk("rst_mid_din", 16'(fifo_bus.fifo_din), 16'd0);
    rst = 1'b0;
    drain("rst_mid", 8, 8'h00, nwr);
    chk("rst_mid_writes", 16'(nwr), 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
